// File: rtl/ps2_key_sequencer.sv
// PS/2 receiver and make/break sequencer driving the active-low SNES word.
// Option macro PS2_PARITY_CHECK_EN enables rejection of bad-parity frames.
module ps2_key_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key_data_out,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        frame_err,
  output logic        break_pending
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } fstate_t;

  typedef enum logic {
    K_MAKE,
    K_BREAK
  } kstate_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat_s;
  logic                   clk_prev;
  logic                   fall;

  fstate_t                fstate;
  fstate_t                fstate_nx;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TW-1:0]          to_cnt;
  logic                   timeout;
  logic                   parity_ok;
  logic                   stop_edge;
  logic                   good;
  logic                   valid_nx;
  logic                   err_nx;

  kstate_t                kstate;
  kstate_t                kstate_nx;
  logic [15:0]            key_nx;
  logic [3:0]             kbit;
  logic                   hit;
  logic                   is_rst;
  logic                   is_e0;
  logic                   is_f0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_s;
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

  // An edge always restarts the idle count, so it beats a timeout.
  assign timeout = (fstate != F_IDLE) && !fall &&
                   (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate <= F_IDLE;
    end else begin
      fstate <= fstate_nx;
    end
  end

  always_comb begin
    fstate_nx = fstate;
    if (timeout) begin
      fstate_nx = F_IDLE;
    end else if (fall) begin
      unique case (fstate)
        F_IDLE:   if (!dat_s) fstate_nx = F_DATA;
        F_DATA:   if (bit_cnt == 3'd7) fstate_nx = F_PARITY;
        F_PARITY: fstate_nx = F_STOP;
        F_STOP:   fstate_nx = F_IDLE;
        default:  fstate_nx = F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (fstate == F_IDLE || fall) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (timeout) begin
        shreg <= '0;
      end else if (fall) begin
        unique case (fstate)
          F_IDLE: bit_cnt <= '0;
          F_DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          F_PARITY: par_bit <= dat_s;
          default: ;
        endcase
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shreg, par_bit};
`else
  logic parity_unused;
  assign parity_unused = par_bit;
  assign parity_ok     = 1'b1;
`endif

  assign stop_edge = fall && (fstate == F_STOP);
  assign good      = dat_s && parity_ok;

  always_comb begin
    valid_nx = stop_edge && good;
    err_nx   = timeout || (stop_edge && !good);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= valid_nx;
      frame_err  <= err_nx;
      if (valid_nx) byte_out <= shreg;
    end
  end

  always_comb begin
    hit  = 1'b1;
    kbit = 4'd0;
    unique case (byte_out)
      8'h2D:   kbit = 4'd15;
      8'h35:   kbit = 4'd14;
      8'h2B:   kbit = 4'd13;
      8'h2C:   kbit = 4'd12;
      8'h1D:   kbit = 4'd11;
      8'h1B:   kbit = 4'd10;
      8'h1C:   kbit = 4'd9;
      8'h23:   kbit = 4'd8;
      8'h24:   kbit = 4'd7;
      8'h34:   kbit = 4'd6;
      default: hit  = 1'b0;
    endcase
  end

  assign is_rst = (byte_out == 8'h00) ||
                  (byte_out == 8'hFF) ||
                  (byte_out == 8'hAA);
  assign is_e0  = (byte_out == 8'hE0);
  assign is_f0  = (byte_out == 8'hF0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kstate       <= K_MAKE;
      key_data_out <= 16'hFFFF;
    end else begin
      kstate       <= kstate_nx;
      key_data_out <= key_nx;
    end
  end

  always_comb begin
    kstate_nx = kstate;
    if (byte_valid) begin
      unique case (1'b1)
        is_rst:  kstate_nx = K_MAKE;
        is_e0:   kstate_nx = kstate;
        is_f0:   kstate_nx = K_BREAK;
        default: kstate_nx = K_MAKE;
      endcase
    end
  end

  // Make clears the mapped bit, break sets it; repeats are idempotent.
  always_comb begin
    key_nx = key_data_out;
    if (byte_valid) begin
      unique case (1'b1)
        is_rst:                    key_nx = 16'hFFFF;
        hit && kstate == K_MAKE:   key_nx[kbit] = 1'b0;
        hit && kstate == K_BREAK:  key_nx[kbit] = 1'b1;
        default: ;
      endcase
    end
    key_nx[5:0] = 6'h3F;
  end

  assign break_pending = (kstate == K_BREAK);

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Front-end controller for the PS/2 keyboard path in the SNES keyboard adapter.
- Oversamples raw ps2_clk/ps2_data in the system clock domain and assembles 11-bit PS/2 frames.
- Sequences received bytes through a make/break state machine and maintains the registered, active-low 16-bit SNES button word that the SNES serial shifter reads.
- Replaces the byte-level combinational decode with clocked break-prefix tracking.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for ps2_clk and ps2_data (legal values 2 or more).
- TIMEOUT_CYCLES, 50000, system clocks without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
- ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
- key_data_out  output  16  SNES button word, active low. Bit map: 15 B, 14 Y, 13 Select, 12 Start, 11 Up, 10 Down, 9 Left, 8 Right, 7 A, 6 X. Bits 5:0 are always 1.
- byte_out  output  8  last good received byte.
- byte_valid  output  1  one-cycle pulse when byte_out is updated.
- frame_err  output  1  one-cycle pulse when a frame is discarded.
- break_pending  output  1  high while an F0 prefix awaits its key byte.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: key_data_out = 16'hFFFF; byte_out = 8'h00; byte_valid = 0; frame_err = 0; break_pending = 0. Synchroniser flops reset to 1. Frame FSM resets to IDLE, key FSM to MAKE, timeout counter and bit counter to 0.
- Reset mid-frame: all state returns to the values above immediately; the partial frame is lost.
- Edge detect: a falling edge is "previous synced clk = 1 and current synced clk = 0". The synced data bit is sampled in the same cycle.
- Frame FSM states:
  - IDLE: on a falling edge with data = 0, go to DATA and clear bit_cnt. A falling edge with data = 1 is ignored with no error.
  - DATA: each falling edge shifts data in LSB first (shift right, new bit enters at [7]). After the 8th bit, go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: on the falling edge, the frame is good if data = 1 and parity is odd over data plus parity bit. A good frame loads byte_out and pulses byte_valid the next cycle. A bad frame pulses frame_err. Both paths return to IDLE.
- Timeout:
  - The counter clears on every falling edge and while in IDLE.
  - Outside IDLE, reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_err; the shift register is discarded.
  - A falling edge and a timeout in the same cycle: the edge wins.
- Key FSM (MAKE, BREAK), evaluated in the byte_valid cycle; key_data_out updates the following cycle:
  - 0x00, 0xFF or 0xAA in any state: key_data_out = FFFF, state = MAKE.
  - 0xE0: ignored, state unchanged.
  - 0xF0: state = BREAK. A repeated F0 stays in BREAK.
  - MAKE state, mapped code: clear its bit. Codes 2D→15, 35→14, 2B→13, 2C→12, 1D→11, 1B→10, 1C→9, 23→8, 24→7, 34→6. Unmapped codes cause no change.
  - BREAK state, mapped code: set its bit. Any non-F0 byte returns the state to MAKE.
- break_pending equals (state == BREAK).
- Typematic repeats of an already-pressed make code are idempotent.
- byte_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: a parity failure discards the frame and pulses frame_err, as described above.
- Undefined: the parity bit is captured but ignored; the frame is good when stop = 1. frame_err then fires only for stop-bit errors and timeouts.

Test Plan:
- Frame 0x1D (start 0, bits 1,0,1,1,1,0,0,0, parity 1, stop 1) → byte_valid pulse, byte_out = 1D, key_data_out = F7FF next cycle.
- Frames F0 then 1D after the previous test → break_pending = 1 after F0, then 0; key_data_out = FFFF.
- Make 1D, make 23 → F6FF. Then F0, 23 → F7FF. Then E0 → no change.
- Frame 0x2D with parity bit 0 → frame_err pulse, no byte_valid, key_data_out unchanged (with PS2_PARITY_CHECK_EN). Without the macro → byte_valid, key_data_out = 7FFF.
- Start bit plus 5 data bits, then idle for TIMEOUT_CYCLES → one frame_err pulse, FSM back in IDLE. The next frame 0x24 decodes correctly → FF7F.
- Make 1D, then byte 0x00 → FFFF. Assert rst_n low mid-frame → all outputs at reset values asynchronously. The first frame after release decodes correctly.
